// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-side arbiter that lets NUM_REQ producers share one FIFO
// write port. Packet mode locks the FIFO to a producer until it marks its last word.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    localparam int PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          wr,
    output logic [DATA_WIDTH-1:0]         w_data,
    output logic                          locked,
    output logic [PTR_W-1:0]              owner
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    state_t           st_q, st_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic [PTR_W-1:0]      win;
    logic [PTR_W-1:0]      cand;
    logic                  found;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            data_arr[i] = data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // NOTE: every signal written here gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = ptr_q;
        if (!reset && !full) begin
            if (st_q == LOCKED) begin
                win   = owner_q;
                found = req[owner_q];
            end else begin
                // Walk ptr, ptr+1, ... with wrap; the first requester wins.
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (!found && req[cand]) begin
                        found = 1'b1;
                        win   = cand;
                    end
                    cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (found) begin
            gnt[win] = 1'b1;
        end
        wr     = found;
        w_data = found ? data_arr[win] : '0;
    end

    always_comb begin
        st_d    = st_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (found) begin
            owner_d = win;
            if (last[win]) begin
                st_d  = IDLE;
                ptr_d = (win == LAST_IDX) ? '0 : win + 1'b1;
            end else begin
                st_d  = LOCKED;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q    <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
        end else begin
            st_q    <= st_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    assign locked = (st_q == LOCKED);
    assign owner  = owner_q;

endmodule
